// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - 8x16 register file with a one-entry write slot that commits only in writeback.
// Optional REGBANK_FWD_EN: Q forwards the pending slot's merged value combinationally.
module reg_bank #(
  parameter bit ZERO_R0 = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state,
  input  logic             wr_req,
  input  logic [2:0]       wr_addr,
  input  logic [15:0]      wr_data,
  input  logic [1:0]       wr_mode,
  output logic [127:0]     Q,
  output logic             pending,
  output logic             wr_ack,
  output logic             ovf,
  output logic [CNT_W-1:0] commit_cnt
);

  localparam logic [1:0] ST_WB = 2'd3;

  logic [15:0] regs [8];
  logic [2:0]  slot_addr;
  logic [15:0] slot_data;
  logic [1:0]  slot_mode;
  logic [15:0] merged;
  logic        commit;
  logic        drop;

  assign commit = pending && (state == ST_WB);
  // Writes to r0 are acknowledged but never land when r0 is hard-wired to zero.
  assign drop   = ZERO_R0 && (slot_addr == 3'd0);

  always_comb begin
    merged = slot_data;
    unique case (slot_mode)
      2'b00:   merged = slot_data;
      2'b01:   merged = {regs[slot_addr][15:8], slot_data[7:0]};
      2'b10:   merged = {slot_data[15:8], regs[slot_addr][7:0]};
      default: merged = {slot_data[7:0], slot_data[15:8]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
      slot_addr  <= 3'd0;
      slot_data  <= 16'h0000;
      slot_mode  <= 2'b00;
      pending    <= 1'b0;
      wr_ack     <= 1'b0;
      ovf        <= 1'b0;
      commit_cnt <= '0;
    end else begin
      wr_ack <= commit;
      if (commit) begin
        if (!drop) regs[slot_addr] <= merged;
        commit_cnt <= commit_cnt + 1'b1;
      end
      // A commit frees the slot on the same edge, so a request there is captured, not dropped.
      if (wr_req && (!pending || commit)) begin
        slot_addr <= wr_addr;
        slot_data <= wr_data;
        slot_mode <= wr_mode;
        pending   <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      if (wr_req && pending && !commit) ovf <= 1'b1;
    end
  end

  always_comb begin
    Q = '0;
    for (int i = 0; i < 8; i++) Q[16*i +: 16] = regs[i];
`ifdef REGBANK_FWD_EN
    if (pending && !drop) Q[16*slot_addr +: 16] = merged;
`endif
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Eight-entry, 16-bit general-purpose register file.
- Presents all registers flattened on a 128-bit bus to the downstream operand-select mux. That mux passes one register through during the decode state.
- Writes arrive from the execute path and are buffered in a one-entry pending slot. They commit only in the writeback state, so the mux never sees a register change mid-instruction.
- Holds a small write-statistics counter and a sticky overflow flag for debug.

Parameters:
- ZERO_R0, 0, when 1 register 0 always reads 0x0000 and writes to it are dropped (still acknowledged).
- CNT_W, 8, width of the commit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- state  in  2  processor phase: 0 fetch, 1 decode, 2 execute, 3 writeback.
- wr_req  in  1  write request strobe, sampled each rising edge.
- wr_addr  in  3  destination register index.
- wr_data  in  16  write data.
- wr_mode  in  2  00 full word, 01 low byte, 10 high byte, 11 swap-write (data bytes swapped before write).
- Q  out  128  register image; register n occupies Q[16n+15:16n].
- pending  out  1  a write is buffered and not yet committed.
- wr_ack  out  1  one-cycle pulse in the cycle after a commit.
- ovf  out  1  sticky: request arrived while slot full and not committing.
- commit_cnt  out  CNT_W  number of commits since reset, wraps.

Behaviour:
- Reset (async, immediate): all registers 0x0000, Q=0, pending=0, wr_ack=0, ovf=0, commit_cnt=0, pending slot cleared.
- Capture: on a rising edge with wr_req=1 and pending=0, latch addr/data/mode into the slot; pending=1 next cycle.
- Commit: on a rising edge with pending=1 and state==3, the target register updates and pending clears. The register update depends on mode:
  - mode 00: full word.
  - mode 01: [7:0] only, [15:8] retained.
  - mode 10: [15:8] from wr_data[15:8], [7:0] retained.
  - mode 11: {data[7:0],data[15:8]}.
- Commit side effects: wr_ack=1 for exactly the following cycle; commit_cnt increments (wraps to 0 at max).
- Q updates on the same edge as the commit. Latency from capture to visible Q is at least 1 cycle and at most until the next writeback edge.
- Simultaneous commit + wr_req on the same edge: the commit completes and the new request is captured; pending stays 1; no overflow.
- wr_req while pending=1 and no commit on that edge: request dropped, ovf set to 1 and held until reset.
- State values other than 3: no commit; the slot holds indefinitely.
- ZERO_R0=1 with wr_addr=0:
  - capture and commit proceed normally; wr_ack pulses and the counter increments;
  - Q[15:0] stays 0.
- Reset asserted mid-operation, including with pending=1: the slot is discarded, no commit occurs, all outputs return to reset values asynchronously.
- No combinational path from write inputs to Q unless the optional feature is enabled.

Optional Feature:
- Macro REGBANK_FWD_EN.
- Defined: Q is combinational. It shows the pending slot's merged value at its target register whenever pending=1, so the decode-stage mux sees the new value before writeback. The architectural register update timing is unchanged.
- Undefined: Q reflects committed registers only (default).

Test Plan:
- Reset check: assert rst mid-cycle with pending=1 → Q=0, pending=0, ovf=0, commit_cnt=0 immediately, and no later commit occurs.
- Full write to R3: wr_addr=3, wr_data=0xBEEF, mode 00 captured in state 2. Q[63:48] stays 0 until the state 3 edge, then reads 0xBEEF; wr_ack pulses one cycle; commit_cnt=1.
- Byte modes: R5=0x1234, then mode 01 data 0x00AB → 0x12AB; mode 10 data 0xCD00 → 0xCDAB; mode 11 data 0x1122 → 0x2211.
- Overflow and back-to-back: a second wr_req in state 2 while pending → ovf=1, first write commits, second never appears. Then wr_req on the commit edge → both the commit and the new capture occur; pending stays 1; ovf unchanged.
- ZERO_R0=1: write 0xFFFF to R0 → Q[15:0]=0, wr_ack pulses, counter increments. CNT_W=2 with 4 commits → commit_cnt wraps to 0.
- REGBANK_FWD_EN defined: capture R7=0x5A5A in state 2 → Q[127:112]=0x5A5A in the same cycle pending rises, before writeback. Undefined: 0 until commit.
